anita3_trigger_event_buffer: RTL and testbench

Captures every issued RF trigger from the simple-trigger stage (trigger strobe, latched 2×NUM_PHI phi pattern, 8-bit RF count) and stamps it with a free-running timestamp and sequence number. Records go into a small FIFO that the downstream readout/event builder drains through a valid/ready handshake. Triggers arriving when the FIFO is full are dropped and counted. Sits directly downstream of the simple trigger, in the clk250 domain.

---
 rtl/anita3_trigger_event_buffer.sv | 123 ++++++++++++
 tb/tb_anita3_trigger_event_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/anita3_trigger_event_buffer.sv
// rtl/anita3_trigger_event_buffer.sv - timestamped RF trigger record FIFO
//
// Purpose:
//   Detects each rising edge of the simple-trigger strobe and captures a
//   record of {phi pattern, RF count, timestamp, sequence number} in a
//   small first-word-fall-through FIFO. The readout drains it through a
//   valid/ready handshake. Edges that arrive while the FIFO is full are
//   dropped and counted in a saturating counter. Sequence numbers advance
//   on every edge, so a gap in evt_seq_o marks a lost trigger.
//
// Ports:
//   clk250_i     250 MHz clock, the only clock
//   rst_i        synchronous active-high reset
//   trig_i       trigger strobe (may be held high; one record per edge)
//   phi_i        {H, V} phi pattern, sampled in the edge cycle
//   count_i      RF count, sampled in the edge cycle
//   evt_valid_o  head record available
//   evt_ready_i  consumer accepts head record
//   evt_phi_o    head record phi pattern
//   evt_count_o  head record RF count
//   evt_time_o   head record timestamp
//   evt_seq_o    head record sequence number
//   level_o      number of stored records, 0..DEPTH
//   ovf_count_o  saturating count of dropped triggers

module anita3_trigger_event_buffer #(
  parameter int NUM_PHI = 16,
  parameter int DEPTH   = 4,
  parameter int TS_BITS = 32
) (
  input  logic                     clk250_i,
  input  logic                     rst_i,
  input  logic                     trig_i,
  input  logic [2*NUM_PHI-1:0]     phi_i,
  input  logic [7:0]               count_i,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [2*NUM_PHI-1:0]     evt_phi_o,
  output logic [7:0]               evt_count_o,
  output logic [TS_BITS-1:0]       evt_time_o,
  output logic [15:0]              evt_seq_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [7:0]               ovf_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [TS_BITS-1:0]   ts;
  logic                 trig_q;
  logic [15:0]          seq;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level;
  logic [7:0]           ovf_cnt;

  logic [2*NUM_PHI-1:0] phi_mem [DEPTH];
  logic [7:0]           cnt_mem [DEPTH];
  logic [TS_BITS-1:0]   ts_mem  [DEPTH];
  logic [15:0]          seq_mem [DEPTH];

  logic push_req;
  logic pop;
  logic push_ok;
  logic drop;

  always_comb begin
    push_req = trig_i && !trig_q;
    pop      = (level != '0) && evt_ready_i;
    // A full FIFO can still take a record if the head leaves this cycle.
    push_ok  = push_req && ((level != FULL_LVL) || pop);
    drop     = push_req && !push_ok;
  end

  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      ts      <= '0;
      trig_q  <= 1'b0;
      seq     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ovf_cnt <= '0;
    end else begin
      ts     <= ts + TS_BITS'(1);
      trig_q <= trig_i;
      if (push_req)
        seq <= seq + 16'd1;
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)
        level <= level + LVL_W'(1);
      else if (pop && !push_ok)
        level <= level - LVL_W'(1);
      if (drop && (ovf_cnt != 8'hFF))
        ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  // Record storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk250_i) begin
    if (push_ok) begin
      phi_mem[wr_ptr] <= phi_i;
      cnt_mem[wr_ptr] <= count_i;
      ts_mem[wr_ptr]  <= ts;
      seq_mem[wr_ptr] <= seq;
    end
  end

  always_comb begin
    evt_valid_o = (level != '0);
    evt_phi_o   = phi_mem[rd_ptr];
    evt_count_o = cnt_mem[rd_ptr];
    evt_time_o  = ts_mem[rd_ptr];
    evt_seq_o   = seq_mem[rd_ptr];
    level_o     = level;
    ovf_count_o = ovf_cnt;
  end

endmodule

// File: tb/tb_anita3_trigger_event_buffer.sv
// tb/tb_anita3_trigger_event_buffer.sv - scoreboard bench for anita3_trigger_event_buffer

module tb_anita3_trigger_event_buffer;

  localparam int NUM_PHI = 16;
  localparam int DEPTH   = 4;
  localparam int TS_BITS = 8;

  typedef struct packed {
    logic [2*NUM_PHI-1:0] phi;
    logic [7:0]           cnt;
    logic [TS_BITS-1:0]   ts;
    logic [15:0]          seq;
  } rec_t;

  logic                 clk250_i = 1'b0;
  logic                 rst_i;
  logic                 trig_i;
  logic [2*NUM_PHI-1:0] phi_i;
  logic [7:0]           count_i;
  logic                 evt_valid_o;
  logic                 evt_ready_i;
  logic [2*NUM_PHI-1:0] evt_phi_o;
  logic [7:0]           evt_count_o;
  logic [TS_BITS-1:0]   evt_time_o;
  logic [15:0]          evt_seq_o;
  logic [2:0]           level_o;
  logic [7:0]           ovf_count_o;

  anita3_trigger_event_buffer #(
    .NUM_PHI(NUM_PHI),
    .DEPTH  (DEPTH),
    .TS_BITS(TS_BITS)
  ) dut (
    .clk250_i   (clk250_i),
    .rst_i      (rst_i),
    .trig_i     (trig_i),
    .phi_i      (phi_i),
    .count_i    (count_i),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_phi_o  (evt_phi_o),
    .evt_count_o(evt_count_o),
    .evt_time_o (evt_time_o),
    .evt_seq_o  (evt_seq_o),
    .level_o    (level_o),
    .ovf_count_o(ovf_count_o)
  );

  always #2 clk250_i = ~clk250_i;

  int total = 0;
  int bad   = 0;

  rec_t               q[$];
  logic [TS_BITS-1:0] ts_m;
  logic [15:0]        seq_m;
  logic [7:0]         ovf_m;
  logic               prev_trig;
  rec_t               last_obs;
  logic [TS_BITS-1:0] prev_t;
  logic               wrap_seen;
  logic [63:0]        snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, update the reference model
  // from the inputs applied during this cycle, then step past the edge.
  task automatic tick();
    logic push_req, pop, full, acc, rst_now;
    rec_t r;
    @(negedge clk250_i);
    chk("valid", 64'(evt_valid_o), 64'(q.size() != 0));
    chk("level", 64'(level_o), 64'(q.size()));
    chk("ovf", 64'(ovf_count_o), 64'(ovf_m));
    full = (q.size() == DEPTH);
    pop  = (q.size() != 0) && evt_ready_i;
    if (pop) begin
      r = q.pop_front();
      last_obs = {evt_phi_o, evt_count_o, evt_time_o, evt_seq_o};
      chk("rec", 64'(last_obs), 64'(r));
      if (evt_time_o < prev_t) wrap_seen = 1'b1;
      prev_t = evt_time_o;
    end
    push_req = trig_i && !prev_trig;
    if (push_req) begin
      acc = !full || pop;
      if (acc) q.push_back({phi_i, count_i, ts_m, seq_m});
      else if (ovf_m != 8'hFF) ovf_m = ovf_m + 8'd1;
      seq_m = seq_m + 16'd1;
    end
    prev_trig = trig_i;
    rst_now = rst_i;
    @(posedge clk250_i);
    #1;
    if (rst_now) begin
      q.delete();
      ts_m = '0; seq_m = '0; ovf_m = '0; prev_trig = 1'b0;
    end else begin
      ts_m = ts_m + 8'd1;
    end
  endtask

  task automatic pulse_edge(input logic [31:0] phi, input logic [7:0] cnt);
    phi_i = phi; count_i = cnt; trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; trig_i = 1'b0; evt_ready_i = 1'b0; phi_i = '0; count_i = '0;
    repeat (2) @(posedge clk250_i);
    #1;
    rst_i = 1'b0;
    q.delete(); ts_m = '0; seq_m = '0; ovf_m = '0; prev_trig = 1'b0;
    prev_t = '0; wrap_seen = 1'b0; last_obs = '0;

    // reset state
    chk("rst_valid", 64'(evt_valid_o), 64'd0);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_ovf", 64'(ovf_count_o), 64'd0);

    // single trigger held 3 cycles
    repeat (10) tick();
    phi_i = 32'h0003_8000; count_i = 8'h05; trig_i = 1'b1;
    tick();
    chk("t1_valid", 64'(evt_valid_o), 64'd1);
    chk("t1_phi", 64'(evt_phi_o), 64'h0003_8000);
    chk("t1_count", 64'(evt_count_o), 64'h05);
    chk("t1_time", 64'(evt_time_o), 64'd10);
    chk("t1_seq", 64'(evt_seq_o), 64'd0);
    repeat (2) tick();
    chk("t1_level_held", 64'(level_o), 64'd1);
    trig_i = 1'b0; evt_ready_i = 1'b1;
    tick();
    chk("t1_pop_valid", 64'(evt_valid_o), 64'd0);
    chk("t1_pop_level", 64'(level_o), 64'd0);
    repeat (3) tick();

    // fill and overflow
    evt_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) pulse_edge(32'h1000_0000 + i, 8'(i + 1));
    chk("fill_level", 64'(level_o), 64'd4);
    chk("fill_ovf", 64'(ovf_count_o), 64'd2);
    evt_ready_i = 1'b1;
    repeat (6) tick();
    chk("fill_last_seq", 64'(last_obs.seq), 64'd3);

    // push and pop while full
    evt_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) pulse_edge(32'h2000_0000 + i, 8'(i + 16));
    phi_i = 32'hABCD_0004; count_i = 8'h44; trig_i = 1'b1; evt_ready_i = 1'b1;
    tick();
    trig_i = 1'b0; evt_ready_i = 1'b0;
    tick();
    chk("pp_level", 64'(level_o), 64'd4);
    chk("pp_ovf", 64'(ovf_count_o), 64'd0);
    evt_ready_i = 1'b1;
    repeat (5) tick();
    chk("pp_last_seq", 64'(last_obs.seq), 64'd4);
    chk("pp_last_phi", 64'(last_obs.phi), 64'hABCD_0004);

    // overflow saturation
    evt_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) pulse_edge(32'(i * 7), 8'(i));
    chk("sat_ovf", 64'(ovf_count_o), 64'd255);
    evt_ready_i = 1'b1;
    repeat (5) tick();

    // timestamp wrap across 0xFF -> 0x00
    while (ts_m != 8'd250) tick();
    wrap_seen = 1'b0; prev_t = '0;
    for (int i = 0; i < 6; i++) begin
      pulse_edge(32'h5555_0000 + i, 8'h80 + 8'(i));
      tick();
    end
    repeat (3) tick();
    chk("ts_wrap", 64'(wrap_seen), 64'd1);

    // mid-operation reset with level 3
    evt_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) pulse_edge(32'h3000_0000 + i, 8'(i));
    chk("mr_level_before", 64'(level_o), 64'd3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mr_valid", 64'(evt_valid_o), 64'd0);
    chk("mr_level", 64'(level_o), 64'd0);
    chk("mr_ovf", 64'(ovf_count_o), 64'd0);
    repeat (5) tick();
    phi_i = 32'h0000_0001; count_i = 8'h09; trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    chk("mr_seq", 64'(evt_seq_o), 64'd0);
    chk("mr_time", 64'(evt_time_o), 64'd5);
    evt_ready_i = 1'b1;
    repeat (3) tick();

    // stall stability while edges keep arriving
    evt_ready_i = 1'b0;
    do_reset();
    pulse_edge(32'hDEAD_BEEF, 8'h77);
    snap = {evt_phi_o, evt_count_o, evt_time_o, evt_seq_o};
    for (int i = 0; i < 20; i++) begin
      phi_i = 32'(i) << 4; count_i = 8'(i); trig_i = (i % 2 == 0);
      tick();
      chk("hold", {evt_phi_o, evt_count_o, evt_time_o, evt_seq_o}, snap);
    end
    trig_i = 1'b0;
    chk("stall_level", 64'(level_o), 64'd4);
    evt_ready_i = 1'b1;
    repeat (6) tick();
    chk("stall_empty", 64'(evt_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
